// File: rtl/decode_queue_if.sv
// Fetch/execute handshake bundle for decode_queue.
// slave: queue side; master: the surrounding pipeline.
interface decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic [31:0]      out_imm;
    logic [1:0]       out_opa_sel;
    logic [1:0]       out_opb_sel;
    logic [4:0]       out_alu_func;
    logic [4:0]       out_dest_idx;
    logic             out_reg_wr;
    logic             out_rd_mem;
    logic             out_wr_mem;
    logic             out_cond_branch;
    logic             out_uncond_branch;
    logic             out_illegal;
    logic [CNT_W-1:0] count;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_imm,
        output out_opa_sel, out_opb_sel, out_alu_func,
        output out_dest_idx, out_reg_wr, out_rd_mem, out_wr_mem,
        output out_cond_branch, out_uncond_branch, out_illegal,
        output count
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_imm,
        input  out_opa_sel, out_opb_sel, out_alu_func,
        input  out_dest_idx, out_reg_wr, out_rd_mem, out_wr_mem,
        input  out_cond_branch, out_uncond_branch, out_illegal,
        input  count
    );
endinterface

// File: rtl/decode_queue.sv
// Pre-decode instruction queue: decodes on entry, DEPTH-entry ring.
// Ports: clk, rst (async, active high), q (decode_queue_if.slave).
// Optional macro DECODE_QUEUE_BYPASS_EN: empty-queue comb bypass.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    decode_queue_if.slave q
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [1:0] OPA_RS1 = 2'd0;
    localparam logic [1:0] OPA_PC  = 2'd1;
    localparam logic [1:0] OPA_ZR  = 2'd2;
    localparam logic [1:0] OPB_RS2 = 2'd0;
    localparam logic [1:0] OPB_IMM = 2'd1;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [1:0]  opa;
        logic [1:0]  opb;
        logic [4:0]  alu;
        logic [4:0]  dest;
        logic        reg_wr;
        logic        rd_mem;
        logic        wr_mem;
        logic        cbr;
        logic        ubr;
        logic        ill;
    } ent_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    ent_t             mem_q [DEPTH];
    ent_t             mem_d [DEPTH];

    ent_t        dec;
    ent_t        head;
    ent_t        out_e;
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        byp;
    logic        out_valid;
    logic        in_ready;
    logic        enq;
    logic        deq;

    assign inst = q.in_inst;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];
    assign rd   = inst[11:7];

    always_comb begin
        dec      = '0;
        dec.pc   = q.in_pc;
        dec.inst = inst;
        dec.ill  = 1'b1;
        case (opc)
            OP_ST: dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BR: dec.imm = {{19{inst[31]}}, inst[31], inst[7],
                              inst[30:25], inst[11:8], 1'b0};
            OP_JAL: dec.imm = {{11{inst[31]}}, inst[31], inst[19:12],
                               inst[20], inst[30:21], 1'b0};
            OP_LUI, OP_AUIPC: dec.imm = {inst[31:12], 12'h000};
            default: dec.imm = {{20{inst[31]}}, inst[31:20]};
        endcase
        case (opc)
            OP_R: begin
                dec.opa    = OPA_RS1;
                dec.opb    = OPB_RS2;
                dec.reg_wr = 1'b1;
                dec.dest   = rd;
                dec.ill    = 1'b0;
                case ({f7, f3})
                    {7'h00, 3'd0}: dec.alu = ALU_ADD;
                    {7'h20, 3'd0}: dec.alu = ALU_SUB;
                    {7'h00, 3'd1}: dec.alu = ALU_SLL;
                    {7'h00, 3'd2}: dec.alu = ALU_SLT;
                    {7'h00, 3'd3}: dec.alu = ALU_SLTU;
                    {7'h00, 3'd4}: dec.alu = ALU_XOR;
                    {7'h00, 3'd5}: dec.alu = ALU_SRL;
                    {7'h20, 3'd5}: dec.alu = ALU_SRA;
                    {7'h00, 3'd6}: dec.alu = ALU_OR;
                    {7'h00, 3'd7}: dec.alu = ALU_AND;
                    default:       dec.ill = 1'b1;
                endcase
            end
            OP_I: begin
                dec.opa    = OPA_RS1;
                dec.opb    = OPB_IMM;
                dec.reg_wr = 1'b1;
                dec.dest   = rd;
                dec.ill    = 1'b0;
                case (f3)
                    3'd0: dec.alu = ALU_ADD;
                    3'd1: dec.alu = ALU_SLL;
                    3'd2: dec.alu = ALU_SLT;
                    3'd3: dec.alu = ALU_SLTU;
                    3'd4: dec.alu = ALU_XOR;
                    3'd5: dec.alu = (|f7) ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
            end
            OP_LD: begin
                dec.opb    = OPB_IMM;
                dec.reg_wr = 1'b1;
                dec.rd_mem = 1'b1;
                dec.dest   = rd;
                dec.ill    = (f3 != 3'd2);
            end
            OP_ST: begin
                dec.opb    = OPB_IMM;
                dec.wr_mem = 1'b1;
                dec.ill    = (f3 != 3'd2);
            end
            OP_BR: begin
                dec.opa = OPA_PC;
                dec.opb = OPB_IMM;
                dec.cbr = 1'b1;
                dec.ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OP_JAL: begin
                dec.opa    = OPA_PC;
                dec.opb    = OPB_IMM;
                dec.ubr    = 1'b1;
                dec.reg_wr = 1'b1;
                dec.dest   = rd;
                dec.ill    = 1'b0;
            end
            OP_JALR: begin
                dec.opb    = OPB_IMM;
                dec.ubr    = 1'b1;
                dec.reg_wr = 1'b1;
                dec.dest   = rd;
                dec.ill    = (f3 != 3'd0);
            end
            OP_LUI: begin
                dec.opa    = OPA_ZR;
                dec.opb    = OPB_IMM;
                dec.reg_wr = 1'b1;
                dec.dest   = rd;
                dec.ill    = 1'b0;
            end
            OP_AUIPC: begin
                dec.opa    = OPA_PC;
                dec.opb    = OPB_IMM;
                dec.reg_wr = 1'b1;
                dec.dest   = rd;
                dec.ill    = 1'b0;
            end
            OP_SYS: dec.ill = (inst[31:20] != 12'h001);
            default: dec.ill = 1'b1;
        endcase
        // Illegal entries still flow down the pipe, but carry no side effects.
        if (dec.ill) begin
            dec.opa    = OPA_RS1;
            dec.opb    = OPB_RS2;
            dec.alu    = ALU_ADD;
            dec.dest   = ZERO_REG;
            dec.reg_wr = 1'b0;
            dec.rd_mem = 1'b0;
            dec.wr_mem = 1'b0;
            dec.cbr    = 1'b0;
            dec.ubr    = 1'b0;
        end
    end

`ifdef DECODE_QUEUE_BYPASS_EN
    assign byp = (count_q == '0) && q.in_valid && !q.flush;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign head      = byp ? dec : mem_q[rd_ptr_q];
    assign out_valid = byp || ((count_q != '0) && !q.flush);
    assign out_e     = out_valid ? head : '0;

    // A bypassed instruction taken by execute never touches storage.
    assign enq = q.in_valid && in_ready && !q.flush
               && !(byp && q.out_ready);
    assign deq = out_valid && q.out_ready && !q.flush && !byp;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
        mem_d    = mem_q;
        if (enq) begin
            mem_d[wr_ptr_q] = dec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign q.in_ready          = in_ready;
    assign q.out_valid         = out_valid;
    assign q.out_pc            = out_e.pc;
    assign q.out_inst          = out_e.inst;
    assign q.out_imm           = out_e.imm;
    assign q.out_opa_sel       = out_e.opa;
    assign q.out_opb_sel       = out_e.opb;
    assign q.out_alu_func      = out_e.alu;
    assign q.out_dest_idx      = out_e.dest;
    assign q.out_reg_wr        = out_e.reg_wr;
    assign q.out_rd_mem        = out_e.rd_mem;
    assign q.out_wr_mem        = out_e.wr_mem;
    assign q.out_cond_branch   = out_e.cbr;
    assign q.out_uncond_branch = out_e.ubr;
    assign q.out_illegal       = out_e.ill;
    assign q.count             = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed scenarios plus random traffic.
// Expected entries come from a reference decoder and an ordered queue.
module tb_decode_queue;
    localparam int DEPTH = 4;
`ifdef DECODE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [1:0]  opa;
        logic [1:0]  opb;
        logic [4:0]  alu;
        logic [4:0]  dest;
        logic        reg_wr;
        logic        rd_mem;
        logic        wr_mem;
        logic        cbr;
        logic        ubr;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pushed_now = 0;
    exp_t sb[$];

    decode_queue_if #(.DEPTH(DEPTH)) bus ();
    decode_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] alu_of(input logic [2:0] f3,
                                         input bit alt);
        case (f3)
            3'd0: return alt ? 5'd1 : 5'd0;
            3'd1: return 5'd7;
            3'd2: return 5'd2;
            3'd3: return 5'd3;
            3'd4: return 5'd6;
            3'd5: return alt ? 5'd9 : 5'd8;
            3'd6: return 5'd5;
            default: return 5'd4;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i,
                                   input logic [31:0] pc);
        exp_t e;
        int   op, f3, f7, rd, sv;
        op = int'(i[6:0]);
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        rd = int'(i[11:7]);
        e = '0;
        e.pc = pc;
        e.inst = i;
        e.ill = 1'b1;
        sv = $signed(i[31:20]);
        e.imm = sv;
        if (op == 'h23) begin
            sv = $signed({i[31:25], i[11:7]});
            e.imm = sv;
        end else if (op == 'h63) begin
            sv = $signed({i[31], i[7], i[30:25], i[11:8]});
            e.imm = sv * 2;
        end else if (op == 'h6f) begin
            sv = $signed({i[31], i[19:12], i[20], i[30:21]});
            e.imm = sv * 2;
        end else if (op == 'h37 || op == 'h17) begin
            e.imm = i[31:12] * 4096;
        end
        case (op)
            'h33: if ((f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5))) begin
                e.ill = 0; e.opb = 0; e.reg_wr = 1; e.dest = rd[4:0];
                e.alu = alu_of(i[14:12], f7 == 'h20);
            end
            'h13: begin
                e.ill = 0; e.opb = 1; e.reg_wr = 1; e.dest = rd[4:0];
                e.alu = alu_of(i[14:12], (f3 == 5) && (f7 != 0));
            end
            'h03: if (f3 == 2) begin
                e.ill = 0; e.opb = 1; e.reg_wr = 1; e.rd_mem = 1;
                e.dest = rd[4:0];
            end
            'h23: if (f3 == 2) begin
                e.ill = 0; e.opb = 1; e.wr_mem = 1;
            end
            'h63: if (f3 != 2 && f3 != 3) begin
                e.ill = 0; e.opa = 1; e.opb = 1; e.cbr = 1;
            end
            'h6f: begin
                e.ill = 0; e.opa = 1; e.opb = 1; e.ubr = 1;
                e.reg_wr = 1; e.dest = rd[4:0];
            end
            'h67: if (f3 == 0) begin
                e.ill = 0; e.opb = 1; e.ubr = 1;
                e.reg_wr = 1; e.dest = rd[4:0];
            end
            'h37: begin
                e.ill = 0; e.opa = 2; e.opb = 1; e.reg_wr = 1;
                e.dest = rd[4:0];
            end
            'h17: begin
                e.ill = 0; e.opa = 1; e.opb = 1; e.reg_wr = 1;
                e.dest = rd[4:0];
            end
            'h73: if (i[31:20] == 12'h001) e.ill = 0;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 10))
            0: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h00;
                    default: ;
                endcase
            end
            1: r[6:0] = 7'h13;
            2: begin
                r[6:0] = 7'h03;
                if ($urandom_range(0, 2) != 0) r[14:12] = 3'd2;
            end
            3: begin
                r[6:0] = 7'h23;
                if ($urandom_range(0, 2) != 0) r[14:12] = 3'd2;
            end
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h6f;
            6: begin
                r[6:0] = 7'h67;
                if ($urandom_range(0, 2) != 0) r[14:12] = 3'd0;
            end
            7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17;
            9: if ($urandom_range(0, 1) != 0) r = 32'h00100073;
               else r[6:0] = 7'h73;
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic rdy,
                         input logic fl);
        @(posedge clk);
        #1;
        chk("count", 32'(bus.count), 32'(sb.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        pushed_now    = 0;
        if (fl) begin
            sb.delete();
        end else if (v && sb.size() < DEPTH) begin
            sb.push_back(model(inst, pc));
            pushed_now = 1;
        end
    endtask

    always @(negedge clk) begin
        int   vis;
        bit   ev;
        exp_t e;
        if (!rst) begin
            vis = sb.size() - (BYP ? 0 : pushed_now);
            ev  = (vis > 0) && !bus.flush;
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) begin
                e = sb[0];
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_inst", bus.out_inst, e.inst);
                chk("out_imm", bus.out_imm, e.imm);
                chk("out_opa", 32'(bus.out_opa_sel), 32'(e.opa));
                chk("out_opb", 32'(bus.out_opb_sel), 32'(e.opb));
                chk("out_alu", 32'(bus.out_alu_func), 32'(e.alu));
                chk("out_dest", 32'(bus.out_dest_idx), 32'(e.dest));
                chk("out_flags",
                    32'({bus.out_reg_wr, bus.out_rd_mem, bus.out_wr_mem,
                         bus.out_cond_branch, bus.out_uncond_branch,
                         bus.out_illegal}),
                    32'({e.reg_wr, e.rd_mem, e.wr_mem,
                         e.cbr, e.ubr, e.ill}));
                if (bus.out_ready) void'(sb.pop_front());
            end else begin
                chk("idle_payload",
                    bus.out_pc | bus.out_inst | bus.out_imm |
                    32'({bus.out_opa_sel, bus.out_opb_sel,
                         bus.out_alu_func, bus.out_dest_idx,
                         bus.out_reg_wr, bus.out_rd_mem, bus.out_wr_mem,
                         bus.out_cond_branch, bus.out_uncond_branch,
                         bus.out_illegal}),
                    32'h0);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        rst = 1'b0;

        // fill while stalled, one extra attempt while full, then drain
        for (int k = 0; k < 4; k++)
            cycle(1, 32'h00500093, 32'(k * 4), 0, 0);
        cycle(1, 32'h00500093, 32'h10, 0, 0);
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // steady stream across pointer wrap
        cycle(1, 32'h00500093, 32'h100, 0, 0);
        for (int k = 1; k <= 10; k++)
            cycle(1, 32'h00208133, 32'(32'h100 + k * 4), 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // illegal LH is queued with side effects stripped
        cycle(1, 32'h00001003, 32'h200, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #1;
        chk("ill_flag", 32'(bus.out_illegal), 32'h1);
        chk("ill_rd_mem", 32'(bus.out_rd_mem), 32'h0);
        chk("ill_reg_wr", 32'(bus.out_reg_wr), 32'h0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // flush with three queued and a same-cycle input
        for (int k = 0; k < 3; k++)
            cycle(1, 32'h00500093, 32'(32'h300 + k * 4), 0, 0);
        cycle(1, 32'h00700113, 32'h30c, 0, 1);
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // asynchronous reset between edges
        cycle(1, 32'h00500093, 32'h400, 0, 0);
        cycle(1, 32'h00500093, 32'h404, 0, 0);
        @(posedge clk);
        #1;
        drive_idle();
        pushed_now = 0;
        chk("pre_rst_count", 32'(bus.count), 32'(sb.size()));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_count", 32'(bus.count), 32'h0);
        sb.delete();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'h1);

        // empty queue, LUI offered with execute ready
        cycle(1, 32'h123452b7, 32'h500, 1, 0);
        #1;
        chk("lui_same_cycle", 32'(bus.out_valid), 32'(BYP));
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // random traffic
        pc = 32'h1000;
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), pc,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
            pc = pc + 4;
        end
        for (int k = 0; k < DEPTH + 1; k++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("final_count", 32'(bus.count), 32'(sb.size()));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised pre-decode instruction queue between the fetch stage and the execute stage. Each accepted instruction is decoded on entry and held, with its decoded control fields and immediate, in a DEPTH-entry circular buffer. Entries are presented to execute with a valid/ready handshake, so fetch and execute can stall independently. The block also supports a single-cycle flush for branch redirects.

## Interface
- DEPTH, 4, number of queue entries; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all entries and any same-cycle enqueue
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept (count < DEPTH)
- in_inst  input  32  instruction word
- in_pc  input  32  instruction PC
- out_valid  output  1  head entry valid
- out_ready  input  1  execute accepts head entry
- out_pc, out_inst  output  32  head PC and raw instruction
- out_imm  output  32  sign-extended immediate, selected by opcode class
- out_opa_sel, out_opb_sel  output  2  ALU operand selects (ALU_OPA_*/ALU_OPB_* encodings)
- out_alu_func  output  5  ALU_* function code
- out_dest_idx  output  5  rd index, or ZERO_REG when the instruction writes no register
- out_reg_wr, out_rd_mem, out_wr_mem, out_cond_branch, out_uncond_branch, out_illegal  output  1  decoded control flags
- count  output  CNT_W  current occupancy

## Operation
- Decoder: combinational on in_inst, using the sys_defs.vh opcode and function encodings.
  - R: 10 ALU ops; any other funct3/funct7 combination is illegal.
  - I-arith: SRAI versus SRLI is chosen by |inst[31:25].
  - Load: only funct3=2 is legal.
  - Store: only funct3=2 is legal.
  - Branch: funct3 2 and 3 are illegal.
  - JAL; JALR (only funct3=0 is legal); LUI (opa=ZR); AUIPC (opa=PC).
  - EBREAK: legal only when imm=0x001.
  - Any other opcode is illegal.
- Immediate: S gives the store displacement; B gives the branch displacement ×2; J gives the jump displacement ×2; LUI/AUIPC give the upper-20 value <<12; all others give the sign-extended inst[31:20].
- Illegal instructions are enqueued with out_illegal=1 and all other control flags cleared. They are not dropped.
- Enqueue happens when in_valid && in_ready && !flush: decoded fields are written at wr_ptr, and wr_ptr increments mod DEPTH.
- Dequeue happens when out_valid && out_ready && !flush: rd_ptr increments mod DEPTH.
- count updates each edge: count + enq - deq. A simultaneous enqueue and dequeue leaves count unchanged.
- in_ready = (count < DEPTH). It is independent of out_ready, so there is no enqueue while full even if a dequeue happens in the same cycle.
- flush: at the next edge, rd_ptr = wr_ptr = 0 and count = 0. out_valid is forced to 0 during the flush cycle.
- When out_valid=0, every out_* payload field is driven to 0, which decodes as a NOP.

## Timing
- Reset (asynchronous) sets: pointers=0, count=0, out_valid=0, in_ready=1, all payload outputs=0. Storage contents are don't-care.
- Reset asserted mid-operation discards every entry immediately, without waiting for a clock edge.
- Enqueue-to-output latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N, if the queue was empty.
- Throughput: 1 instruction per cycle in and out when count is between 1 and DEPTH-1.
- Pointer wrap: after DEPTH-1, a pointer returns to 0. Full is detected by count==DEPTH, not by pointer equality.
- Outputs are registered-storage reads: the head is indexed by rd_ptr, with no combinational path from in_* to out_* (except with the macro below).

## Configuration
- DECODE_QUEUE_BYPASS_EN defined:
  - When count==0 and in_valid && !flush, out_* are driven combinationally from the decoder, with out_valid=1 in the same cycle.
  - If out_ready is also 1, the instruction is consumed directly: it is not written, and count stays 0.
  - If out_ready=0, it is enqueued normally.
- Not defined: no in_* → out_* combinational path; latency is always at least 1 cycle.

## Test plan
- Fill and drain, DEPTH=4, out_ready=0: four enqueues of ADDI x1,x0,5 (0x00500093) at PC 0x0,0x4,0x8,0xC.
  - Required: count reaches 4 and in_ready=0.
  - Then raise out_ready: out_pc is 0x0,0x4,0x8,0xC on consecutive cycles, out_imm=5, out_dest_idx=1.
- Wrap-around: run 10 back-to-back enqueue/dequeue pairs.
  - Required: count holds at 1, PCs are delivered in order, and no entry is lost across the pointer wrap.
- Illegal: enqueue 0x0000A003 (load funct3=2? no — use LH, 0x00001003).
  - Required: out_illegal=1, out_rd_mem=0, out_reg_wr=0.
- Flush: with count=3, assert flush together with in_valid.
  - Required: out_valid=0 in that cycle, count=0 next cycle, and the same-cycle input is not enqueued.
- Async reset: with count=2, assert rst between edges.
  - Required: out_valid=0 and count=0 immediately; in_ready=1 after release.
- Bypass (macro defined): with the queue empty, in_valid=1 with LUI x5,0x12345 (0x123452B7) and out_ready=1.
  - Required: out_valid=1 in the same cycle, out_imm=0x12345000, count stays 0.
  - Without the macro: out_valid rises one cycle later.
